// File: rtl/accu_alu_seq.sv
// Accumulator/ALU execution core: WIDTH-bit accumulator A, operand B from bus 1,
// registered c/z/n flags and an iterative shift-add multiply with busy/done.
module accu_alu_seq #(
  parameter int WIDTH  = 4,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             accu_en,
  input  logic             bus1_en,
  input  logic             bus2_en,
  input  logic [WIDTH-1:0] in_bus1,
  input  logic [3:0]       sel,
  output logic             busy,
  output logic             done,
  output logic             c,
  output logic             z,
  output logic             n,
  output logic [WIDTH-1:0] out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_PASS_A = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_PASS_B = 4'b0010;
  localparam logic [3:0] OP_ADD    = 4'b0011;
  localparam logic [3:0] OP_NAND   = 4'b0100;
  localparam logic [3:0] OP_AND    = 4'b0101;
  localparam logic [3:0] OP_OR     = 4'b0110;
  localparam logic [3:0] OP_XOR    = 4'b0111;
  localparam logic [3:0] OP_SHL    = 4'b1000;
  localparam logic [3:0] OP_SHR    = 4'b1001;
  localparam logic [3:0] OP_ROL    = 4'b1010;
  localparam logic [3:0] OP_MUL    = 4'b1011;
  localparam logic [3:0] OP_CLR    = 4'b1100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t                 state_q;
  logic [WIDTH-1:0]       a_q;
  logic                   c_q, z_q, n_q;
  logic                   busy_q, done_q;
  logic [2*WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]       mplier_q;
  logic [2*WIDTH-1:0]     prod_q;
  logic [CW-1:0]          cnt_q;

  logic [WIDTH-1:0]       b;
  logic [WIDTH:0]         sum_add, sum_sub;
  logic [WIDTH-1:0]       r;
  logic                   cf;
  logic                   wr_class;
  logic                   issue_alu, issue_mul;
  logic [2*WIDTH-1:0]     prod_d;
  logic                   mul_last;

  // Combinational ALU result and carry candidate for the current sel.
  always_comb begin
    b        = bus1_en ? in_bus1 : '0;
    sum_add  = {1'b0, a_q} + {1'b0, b};
    sum_sub  = {1'b0, a_q} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    r        = a_q;
    cf       = 1'b0;
    wr_class = 1'b1;
    case (sel)
      OP_PASS_A: r = a_q;
      OP_SUB:    begin r = sum_sub[WIDTH-1:0]; cf = sum_sub[WIDTH]; end
      OP_PASS_B: r = b;
      OP_ADD:    begin r = sum_add[WIDTH-1:0]; cf = sum_add[WIDTH]; end
      OP_NAND:   r = ~(a_q & b);
      OP_AND:    r = a_q & b;
      OP_OR:     r = a_q | b;
      OP_XOR:    r = a_q ^ b;
      OP_SHL:    begin r = {a_q[WIDTH-2:0], 1'b0}; cf = a_q[WIDTH-1]; end
      OP_SHR:    begin r = {1'b0, a_q[WIDTH-1:1]}; cf = a_q[0]; end
      OP_ROL:    begin r = {a_q[WIDTH-2:0], a_q[WIDTH-1]}; cf = a_q[WIDTH-1]; end
      OP_CLR:    r = '0;
      default:   wr_class = 1'b0;
    endcase
  end

  assign issue_alu = accu_en && (state_q == S_IDLE) && wr_class;
  assign issue_mul = MUL_EN && accu_en && (state_q == S_IDLE) && (sel == OP_MUL);

  // One multiplier bit per cycle; the final step's sum is written straight to A.
  assign prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (issue_mul) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_q};
            mplier_q <= b;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_MUL;
          end else if (issue_alu) begin
            a_q <= r;
            c_q <= cf;
            z_q <= (r == '0);
            n_q <= r[WIDTH-1];
          end
        end
        S_MUL: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (mul_last) begin
            a_q     <= prod_d[WIDTH-1:0];
            c_q     <= |prod_d[2*WIDTH-1:WIDTH];
            z_q     <= (prod_d[WIDTH-1:0] == '0);
            n_q     <= prod_d[WIDTH-1];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out  = (bus2_en && !busy_q) ? r : '0;
  assign busy = busy_q;
  assign done = done_q;
  assign c    = c_q;
  assign z    = z_q;
  assign n    = n_q;

endmodule

// File: tb/tb_accu_alu_seq.sv
// Directed bench for accu_alu_seq (WIDTH=4) with a MUL_EN=0 instance alongside;
// expected {A,c,z,n} words go through a queue and are checked after each write edge.
module tb_accu_alu_seq;
  localparam int W = 4;

  localparam logic [3:0] OP_PASS_A = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_PASS_B = 4'b0010;
  localparam logic [3:0] OP_ADD    = 4'b0011;
  localparam logic [3:0] OP_NAND   = 4'b0100;
  localparam logic [3:0] OP_AND    = 4'b0101;
  localparam logic [3:0] OP_OR     = 4'b0110;
  localparam logic [3:0] OP_XOR    = 4'b0111;
  localparam logic [3:0] OP_SHL    = 4'b1000;
  localparam logic [3:0] OP_SHR    = 4'b1001;
  localparam logic [3:0] OP_ROL    = 4'b1010;
  localparam logic [3:0] OP_MUL    = 4'b1011;
  localparam logic [3:0] OP_CLR    = 4'b1100;
  localparam logic [3:0] OP_NOP    = 4'b1101;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         accu_en, nm_accu_en, bus1_en, bus2_en;
  logic [W-1:0] in_bus1;
  logic [3:0]   sel;
  logic         busy, done, c, z, n;
  logic [W-1:0] out;
  logic         busy_nm, done_nm, c_nm, z_nm, n_nm;
  logic [W-1:0] out_nm;

  accu_alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .accu_en(accu_en), .bus1_en(bus1_en),
    .bus2_en(bus2_en), .in_bus1(in_bus1), .sel(sel), .busy(busy),
    .done(done), .c(c), .z(z), .n(n), .out(out)
  );

  accu_alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) u_nomul (
    .clk(clk), .reset(reset), .accu_en(nm_accu_en), .bus1_en(bus1_en),
    .bus2_en(bus2_en), .in_bus1(in_bus1), .sel(sel), .busy(busy_nm),
    .done(done_nm), .c(c_nm), .z(z_nm), .n(n_nm), .out(out_nm)
  );

  int errors = 0;
  int checks = 0;
  logic [W+2:0] exp_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [3:0] s, input logic [W-1:0] b, input logic b1, input logic aen);
    sel        = s;
    in_bus1    = b;
    bus1_en    = b1;
    accu_en    = aen;
    nm_accu_en = aen;
  endtask

  task automatic step(input logic [3:0] s, input logic [W-1:0] b, input logic b1, input logic aen);
    @(negedge clk);
    drive(s, b, b1, aen);
    @(posedge clk);
    #1;
  endtask

  // scoreboard: pop one expected state and read A back through PASS_A
  task automatic check_state(input string tag);
    logic [W+2:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, " queue_empty"}, 16'd1, 16'd0);
    end else begin
      e          = exp_q.pop_front();
      accu_en    = 1'b0;
      nm_accu_en = 1'b0;
      sel        = OP_PASS_A;
      bus2_en    = 1'b1;
      #1;
      chk({tag, " A"}, 16'(out), 16'(e[W+2:3]));
      chk({tag, " c"}, 16'(c), 16'(e[2]));
      chk({tag, " z"}, 16'(z), 16'(e[1]));
      chk({tag, " n"}, 16'(n), 16'(e[0]));
    end
  endtask

  task automatic op(input string tag, input logic [3:0] s, input logic [W-1:0] b,
                    input logic b1, input logic aen,
                    input logic [W-1:0] ea, input logic ec, input logic ez, input logic en);
    exp_q.push_back({ea, ec, ez, en});
    step(s, b, b1, aen);
    check_state(tag);
  endtask

  task automatic mul_run(input string tag, input logic [W-1:0] b,
                         input logic [W-1:0] ea, input logic ec, input logic ez, input logic en,
                         input logic [W-1:0] nm_a);
    int cycles;
    exp_q.push_back({ea, ec, ez, en});
    bus2_en = 1'b1;
    step(OP_MUL, b, 1'b1, 1'b1);
    chk({tag, " busy_issue"}, 16'(busy), 16'd1);
    chk({tag, " out_busy"}, 16'(out), 16'd0);
    chk({tag, " nomul_busy"}, 16'(busy_nm), 16'd0);
    cycles = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sel        = 4'($urandom_range(0, 15));
      in_bus1    = W'($urandom_range(0, 15));
      bus1_en    = 1'($urandom_range(0, 1));
      accu_en    = 1'b1;
      nm_accu_en = 1'b0;
      @(posedge clk);
      #1;
      if (!busy) break;
      cycles++;
    end
    chk({tag, " busy_cycles"}, 16'(cycles), 16'd4);
    chk({tag, " done_pulse"}, 16'(done), 16'd1);
    check_state(tag);
    chk({tag, " nomul_A"}, 16'(out_nm), 16'(nm_a));
    chk({tag, " nomul_done"}, 16'(done_nm), 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    reset   = 1'b1;
    bus2_en = 1'b1;
    drive(OP_PASS_A, '0, 1'b0, 1'b0);
    #12;
    chk("rst busy", 16'(busy), 16'd0);
    chk("rst done", 16'(done), 16'd0);
    chk("rst c", 16'(c), 16'd0);
    chk("rst z", 16'(z), 16'd0);
    chk("rst n", 16'(n), 16'd0);
    chk("rst A", 16'(out), 16'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back({W'(i), 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      drive(OP_ADD, 4'b0001, 1'b1, 1'b1);
      #1;
      chk("add_out", 16'(out), 16'(i));
      @(posedge clk);
      #1;
      check_state("add_inc");
    end

    op("passb_f",  OP_PASS_B, 4'hf, 1, 1, 4'hf, 0, 0, 1);
    op("add_wrap", OP_ADD,    4'h1, 1, 1, 4'h0, 1, 1, 0);
    op("sub_brw",  OP_SUB,    4'h3, 1, 1, 4'hd, 0, 0, 1);
    op("passb_5",  OP_PASS_B, 4'h5, 1, 1, 4'h5, 0, 0, 0);
    op("sub_nbrw", OP_SUB,    4'h3, 1, 1, 4'h2, 1, 0, 0);
    op("add_b1off", OP_ADD,   4'h7, 0, 1, 4'h2, 0, 0, 0);
    bus2_en = 1'b0;
    #1;
    chk("bus2_off out", 16'(out), 16'd0);
    bus2_en = 1'b1;

    op("ld_c",  OP_PASS_B, 4'hc, 1, 1, 4'hc, 0, 0, 1);
    op("nand",  OP_NAND,   4'ha, 1, 1, 4'h7, 0, 0, 0);
    op("ld_c",  OP_PASS_B, 4'hc, 1, 1, 4'hc, 0, 0, 1);
    op("and",   OP_AND,    4'ha, 1, 1, 4'h8, 0, 0, 1);
    op("ld_c",  OP_PASS_B, 4'hc, 1, 1, 4'hc, 0, 0, 1);
    op("or",    OP_OR,     4'ha, 1, 1, 4'he, 0, 0, 1);
    op("ld_c",  OP_PASS_B, 4'hc, 1, 1, 4'hc, 0, 0, 1);
    op("xor",   OP_XOR,    4'ha, 1, 1, 4'h6, 0, 0, 0);
    op("ld_9",  OP_PASS_B, 4'h9, 1, 1, 4'h9, 0, 0, 1);
    op("shl",   OP_SHL,    4'h0, 1, 1, 4'h2, 1, 0, 0);
    op("ld_9",  OP_PASS_B, 4'h9, 1, 1, 4'h9, 0, 0, 1);
    op("rol",   OP_ROL,    4'h0, 1, 1, 4'h3, 1, 0, 0);
    op("shr",   OP_SHR,    4'h0, 1, 1, 4'h1, 1, 0, 0);
    op("clr",   OP_CLR,    4'h5, 1, 1, 4'h0, 0, 1, 0);
    op("nop",   OP_NOP,    4'h5, 1, 1, 4'h0, 0, 1, 0);
    op("aen_off", OP_ADD,  4'h5, 1, 0, 4'h0, 0, 1, 0);

    op("ld_3", OP_PASS_B, 4'h3, 1, 1, 4'h3, 0, 0, 0);
    mul_run("mul3x5", 4'h5, 4'hf, 0, 0, 1, 4'h3);
    op("b2b_ld7", OP_PASS_B, 4'h7, 1, 1, 4'h7, 0, 0, 0);
    chk("done_clear", 16'(done), 16'd0);
    mul_run("mul7x7", 4'h7, 4'h1, 1, 0, 0, 4'h7);

    op("ld_b", OP_PASS_B, 4'hb, 1, 1, 4'hb, 0, 0, 1);
    step(OP_MUL, 4'h5, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("abort busy_pre", 16'(busy), 16'd1);
    reset = 1'b1;
    #1;
    chk("abort busy", 16'(busy), 16'd0);
    chk("abort done", 16'(done), 16'd0);
    chk("abort c", 16'(c), 16'd0);
    chk("abort z", 16'(z), 16'd0);
    chk("abort n", 16'(n), 16'd0);
    accu_en    = 1'b0;
    nm_accu_en = 1'b0;
    sel        = OP_PASS_A;
    bus2_en    = 1'b1;
    #1;
    chk("abort A", 16'(out), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      dn += int'(done);
    end
    chk("abort no_done", 16'(dn), 16'd0);
    chk("abort busy_after", 16'(busy), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accu_alu_seq.md
Name: accu_alu_seq

Overview:
- Parametrised successor to the 4-bit accumulator/ALU datapath.
- A WIDTH-bit accumulator A combines with operand B from input bus 1 through an extended ALU; the result drives output bus 2.
- Adds registered flags (c, z, n), shift/rotate/logic ops, and an iterative multi-cycle multiply with busy/done handshake.
- Sits as the execution core behind the lab sequencer/control FSM.

Parameters:
- WIDTH, 4, datapath width in bits; minimum 2.
- MUL_EN, 1, 1 = MUL op implemented; 0 = MUL encoding treated as NOP.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- accu_en  input  1  accumulator/flag write enable for the current op.
- bus1_en  input  1  1: B = in_bus1; 0: B = 0.
- bus2_en  input  1  1: out drives result; 0: out = 0.
- in_bus1  input  WIDTH  operand B source.
- sel  input  4  operation select.
- busy  output  1  multiply in progress.
- done  output  1  one-cycle pulse when the multiply result is written.
- c  output  1  registered carry flag.
- z  output  1  registered zero flag.
- n  output  1  registered sign flag (MSB of the written result).
- out  output  WIDTH  output bus 2.

Behaviour:
- Reset (async): A=0; c=0; z=0; n=0; busy=0; done=0; multiply state cleared. A reset during a multiply aborts it; A is not written.
- Combinational result R(A,B,sel):
  - 0000 PASS_A: R=A, c'=0.
  - 0001 SUB: R=A-B mod 2^WIDTH, c'=carry-out of A+~B+1 (1 = no borrow).
  - 0010 PASS_B: R=B, c'=0.
  - 0011 ADD: R=A+B mod 2^WIDTH, c'=carry-out.
  - 0100 NAND, 0101 AND, 0110 OR, 0111 XOR: bitwise, c'=0.
  - 1000 SHL: R=A<<1, c'=A[MSB].
  - 1001 SHR (logical): R=A>>1, c'=A[0].
  - 1010 ROL: R={A[MSB-1:0],A[MSB]}, c'=A[MSB].
  - 1011 MUL: multi-cycle, see below.
  - 1100 CLR: R=0, c'=0.
  - 1101–1111 NOP: no write.
- Single-cycle write: at a rising edge with accu_en=1, busy=0 and a non-NOP, non-MUL sel:
  - A<=R; c<=c'; z<=(R==0); n<=R[MSB].
  - Otherwise A and the flags hold.
- out = bus2_en ? R : 0, combinational. While busy=1, out=0.
- MUL (MUL_EN=1), issued at edge k when sel=1011, accu_en=1, busy=0:
  - Latch multiplicand=A and multiplier=B; clear the 2*WIDTH product register; busy=1 from k.
  - Shift-add, one multiplier bit per cycle, for WIDTH cycles.
  - At edge k+WIDTH: A<=product[WIDTH-1:0]; c<=|product[2W-1:W] (overflow); z<=(low half==0); n<=low MSB; busy<=0; done<=1.
  - done returns to 0 at edge k+WIDTH+1.
- While busy=1, sel, accu_en, bus1_en and in_bus1 are ignored; operands were latched at issue.
- MUL with MUL_EN=0 behaves as NOP.
- Back-to-back: a new op, including MUL, may issue on the edge after busy falls, i.e. in the cycle where done=1.

Test Plan:
- WIDTH=4. reset=1, then 0; ADD, in_bus1=0001, accu_en=1 for 4 cycles -> A=1,2,3,4; out=A+1; c=0, z=0.
- A=1111, ADD with B=0001 -> A=0000, c=1, z=1. Then SUB with B=0011 -> A=1101, c=0, n=1. Then SUB A=0101, B=0011 -> 0010, c=1.
- bus1_en=0 with ADD -> A unchanged (B=0), c=0; bus2_en=0 -> out=0000. Logic ops: A=1100, B=1010 -> NAND 0111, AND 1000, OR 1110, XOR 0110. SHL of 1001 -> 0010, c=1; ROL of 1001 -> 0011.
- MUL A=0011, B=0101 -> busy=1 for 4 cycles, then A=1111, c=0, done pulses 1 cycle. Next, MUL A=0111, B=0111 -> A=0001, c=1 (49). Toggling sel/in_bus1 during busy has no effect.
- Reset asserted mid-MUL (2nd busy cycle) -> busy, done, A, flags all 0 immediately; no done pulse. MUL_EN=0 build: MUL leaves A and flags unchanged and busy stays 0.
